// File: rtl/serial_adder_defs.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_defs;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder, purely combinational; the serial datapath's only adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through a single full-adder
// cell, one bit per clock, and the completed result is published on done.
module serial_adder
   import serial_adder_defs::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             cell_s, cell_c;

   fa_cell u_fa_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (c_q),
      .sum  (cell_s),
      .cout (cell_c)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ps_d    = ps_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               c_d     = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            ps_d  = {cell_s, ps_q[WIDTH-1:1]};
            c_d   = cell_c;
            cnt_d = cnt_q + CW'(1);
            // Last bit: publish the shifted-in value directly, not the stale ps_q.
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {cell_s, ps_q[WIDTH-1:1]};
               cout_d  = cell_c;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ps_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ps_q    <= ps_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == RUN) || (state_q == DONE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with hand-computed expectations.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] op_a, op_b;
   logic       cin;
   logic       busy, done;
   logic [7:0] sum;
   logic       cout;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one add from IDLE and check latency and result; returns in IDLE.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] exp_s, input logic exp_c);
      int n;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; cin = ci;
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom; cin = 1'b0;
      n = 1;
      check({tag, "_busy"}, busy, 1);
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, 9);
      check({tag, "_sum"}, sum, exp_s);
      check({tag, "_cout"}, cout, exp_c);
      @(negedge clk);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_done"}, done, 0);
   endtask

   initial begin
      logic [7:0] held_s;
      logic       held_c;
      int         n_done;
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic       vc [3];
      logic [7:0] vs [3];
      logic       vco [3];
      int         acc_idx, done_idx, last_acc, cyc;

      // Reset with start held high: start must be dropped.
      reset = 1'b1; start = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 8'h00);
      check("rst_cout", cout, 0);

      run_op("add5A3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_hold_sum", sum, 8'h96);
      run_op("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("addFFFF1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Re-pulse start during RUN: ignored, exactly one done.
      @(negedge clk);
      start = 1'b1; op_a = 8'h0F; op_b = 8'h01; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int n = 1; n <= 20; n++) begin
         if (n == 3) begin
            start = 1'b1; op_a = 8'h11; op_b = 8'h22; cin = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (n <= 9) check("repulse_busy", busy, 1);
         if (n == 9) begin
            check("repulse_done", done, 1);
            check("repulse_sum", sum, 8'h10);
            check("repulse_cout", cout, 0);
         end
         if (done) n_done++;
         @(negedge clk);
      end
      check("repulse_ndone", n_done, 1);

      // Reset on the 4th RUN cycle aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_sum", sum, 8'h00);
      check("abort_cout", cout, 0);
      n_done = 0;
      for (int n = 0; n < 12; n++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      check("abort_ndone", n_done, 0);
      run_op("add0304", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

      // start held high continuously: accepts every 10 cycles.
      va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0; vs[0] = 8'h46; vco[0] = 1'b0;
      va[1] = 8'h80; vb[1] = 8'h80; vc[1] = 1'b1; vs[1] = 8'h01; vco[1] = 1'b1;
      va[2] = 8'h7F; vb[2] = 8'h01; vc[2] = 1'b0; vs[2] = 8'h80; vco[2] = 1'b0;
      acc_idx = 0; done_idx = 0; last_acc = 0; cyc = 0;
      held_s = sum; held_c = cout;
      while (done_idx < 3 && cyc < 60) begin
         if (done) begin
            check("b2b_sum", sum, vs[done_idx]);
            check("b2b_cout", cout, vco[done_idx]);
            held_s = sum; held_c = cout;
            done_idx++;
         end else if (done_idx > 0) begin
            check("b2b_hold", {sum, cout}, {held_s, held_c});
         end
         if (!busy) begin
            if (acc_idx < 3) begin
               if (acc_idx > 0) check("b2b_interval", cyc - last_acc, 10);
               last_acc = cyc;
               start = 1'b1;
               op_a = va[acc_idx]; op_b = vb[acc_idx]; cin = vc[acc_idx];
               acc_idx++;
            end else begin
               start = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("b2b_ndone", done_idx, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to add op_a, op_b and cin; honoured only in IDLE.
REQ-005 SHALL have port op_a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 SHALL have port op_b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; sum and cout are valid in this cycle.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until the next completion.
REQ-011 SHALL have port cout  output  1  registered carry-out, held until the next completion.

Function
REQ-012 SHALL implement the three-state FSM IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL, on the clock edge: load shift registers A<=op_a and B<=op_b, set the carry flop to cin, clear the bit counter to 0, and go to RUN.
REQ-014 In RUN, each cycle SHALL drive the full-adder bit cell with A[0], B[0] and the carry flop.
REQ-015 On each RUN edge, A and B SHALL shift right by one, the cell sum SHALL be shifted into the MSB of a partial-sum register, the carry flop SHALL take the cell carry-out, and the counter SHALL increment.
REQ-016 When the counter equals WIDTH-1 in RUN, the next edge SHALL: copy the completed partial sum to sum, copy the cell carry-out to cout, and go to DONE.
REQ-017 RUN SHALL therefore last exactly WIDTH cycles.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k SHALL give done=1 in the cycle following edge k+WIDTH.
REQ-020 start SHALL be ignored in RUN and DONE; there is no queuing, and the in-flight operation and captured operands SHALL be unaffected.
REQ-021 After DONE, start SHALL be accepted no earlier than the next IDLE cycle, giving a minimum issue interval of WIDTH+2 cycles.
REQ-022 op_a, op_b and cin SHALL be don't-care outside the accept cycle.
REQ-023 The result SHALL equal (op_a + op_b + cin) mod 2^WIDTH, with cout = bit WIDTH of that full sum.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap during a valid operation.
REQ-025 sum and cout SHALL change only on the edge entering DONE or on reset, and SHALL be stable in IDLE.

Reset
REQ-026 reset=1 SHALL, on the edge, force IDLE and clear all of: A, B, the partial-sum register, the carry flop, the counter, sum, cout, busy and done.
REQ-027 Reset SHALL take priority over start and over any in-progress RUN or DONE; an aborted operation SHALL produce no done pulse.
REQ-028 start asserted in the same cycle as reset SHALL be dropped.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package/include file serial_adder_defs.
REQ-030 The one-bit adder SHALL be a separate purely combinational sub-module fa_cell (inputs a, b, cin; outputs sum, cout), instantiated exactly once.
REQ-031 The FSM, shift registers and counter SHALL reside in serial_adder.

Verification
REQ-032 WIDTH=8, op_a=8'h5A, op_b=8'h3C, cin=0 -> done exactly 9 cycles after the accept edge, sum=8'h96, cout=0.
REQ-033 op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1; then op_a=8'hFF, op_b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-034 start re-pulsed with op_a=8'h11 during RUN of 8'h0F+8'h01 -> exactly one done pulse, sum=8'h10, busy held high throughout.
REQ-035 reset asserted for 1 cycle on the 4th RUN cycle -> busy=0, done never pulses, sum=8'h00, cout=0; a following start of 8'h03+8'h04 -> sum=8'h07.
REQ-036 Back-to-back starts held high continuously -> accepts spaced exactly 10 cycles apart; each sum is correct; sum is unchanged between done pulses.
